// File: rtl/debounced_state_stepper_if.sv
// Pin-side bundle for debounced_state_stepper: raw buttons and jump request in,
// current state, one-hot LEDs and step strobe out.
interface debounced_state_stepper_if #(
  parameter int unsigned NUM_STATES = 4,
  parameter int unsigned SW         = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) ();

  logic                  btn_next_raw;
  logic                  btn_prev_raw;
  logic                  jump;
  logic [SW-1:0]         jump_state;
  logic [SW-1:0]         state;
  logic [NUM_STATES-1:0] led;
  logic                  step_pulse;

  modport master (
    output btn_next_raw, btn_prev_raw, jump, jump_state,
    input  state, led, step_pulse
  );

  modport slave (
    input  btn_next_raw, btn_prev_raw, jump, jump_state,
    output state, led, step_pulse
  );

endinterface

// File: rtl/debounced_state_stepper.sv
// Two debounced push-buttons step a NUM_STATES state register up/down, with optional
// wrap and a direct jump; drives a one-hot LED vector and a registered step strobe.
module debounced_state_stepper #(
  parameter int unsigned NUM_STATES     = 4,
  parameter int unsigned DEBOUNCE_BITS  = 16,
  parameter bit          WRAP           = 1'b1,
  parameter int unsigned INIT_STATE     = 0,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  debounced_state_stepper_if.slave   bus_io
);

  localparam int unsigned SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [SW-1:0] MaxState  = SW'(NUM_STATES - 1);
  localparam logic [SW-1:0] InitState = SW'(INIT_STATE);

  // Index 0 is the "next" button, index 1 the "prev" button; all levels are pressed=1.
  logic [1:0] raw_pressed;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] deb_q, deb_d;
  logic [1:0] evt;
  logic [DEBOUNCE_BITS-1:0] cnt_q [2];
  logic [DEBOUNCE_BITS-1:0] cnt_d [2];

  logic [SW-1:0] state_q, state_d;
  logic          step_q, step_d;
  logic          state_legal, jump_legal;
  logic [NUM_STATES-1:0] led;

  assign raw_pressed = {bus_io.btn_prev_raw, bus_io.btn_next_raw} ^ {2{BTN_ACTIVE_LOW}};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      evt[i]   = 1'b0;
      if (sync2_q[i] != deb_q[i]) begin
        if (&cnt_q[i]) begin
          deb_d[i] = sync2_q[i];
          evt[i]   = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEBOUNCE_BITS'(1);
        end
      end
    end
  end

  // With a power-of-two state count every encoding is legal.
  if (NUM_STATES == (1 << SW)) begin : g_pow2
    assign state_legal = 1'b1;
    assign jump_legal  = 1'b1;
  end else begin : g_npow2
    assign state_legal = (state_q <= MaxState);
    assign jump_legal  = (bus_io.jump_state <= MaxState);
  end

  always_comb begin
    state_d = state_q;
    if (!state_legal) begin
      state_d = InitState;
    end else if (evt[0] && evt[1]) begin
      state_d = state_q;
    end else if (evt[0]) begin
      if (state_q == MaxState) begin
        if (WRAP) state_d = '0;
      end else begin
        state_d = state_q + SW'(1);
      end
    end else if (evt[1]) begin
      if (state_q == '0) begin
        if (WRAP) state_d = MaxState;
      end else begin
        state_d = state_q - SW'(1);
      end
    end else if (bus_io.jump && jump_legal) begin
      state_d = bus_io.jump_state;
    end
    step_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '{default: '0};
      state_q <= InitState;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= raw_pressed;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      led[i] = (state_q == SW'(i));
    end
  end

  assign bus_io.state      = state_q;
  assign bus_io.led        = led;
  assign bus_io.step_pulse = step_q;

endmodule
